// File: rtl/vliw_fetch_if.sv
// ----------------------------------------------------------------------------
// vliw_fetch_if
//   Bundle fetch bus between the fetch stage, the instruction memory and the
//   decode stage.
//   master (fetch side):
//     in : stall, dec_stall, redirect, redirect_pc, imem_data
//     out: imem_addr, inst, inst_pc, inst_valid
//   slave (memory / decode / control side): same signals, opposite direction.
// ----------------------------------------------------------------------------
interface vliw_fetch_if #(
    parameter int PC_W     = 14,
    parameter int BUNDLE_W = 128
);
    logic                stall;
    logic                dec_stall;
    logic                redirect;
    logic [PC_W-1:0]     redirect_pc;
    logic [PC_W-1:0]     imem_addr;
    logic [BUNDLE_W-1:0] imem_data;
    logic [BUNDLE_W-1:0] inst;
    logic [PC_W-1:0]     inst_pc;
    logic                inst_valid;

    modport master (
        input  stall, dec_stall, redirect, redirect_pc, imem_data,
        output imem_addr, inst, inst_pc, inst_valid
    );

    modport slave (
        output stall, dec_stall, redirect, redirect_pc, imem_data,
        input  imem_addr, inst, inst_pc, inst_valid
    );
endinterface

// File: rtl/vliw_fetch.sv
// ----------------------------------------------------------------------------
// vliw_fetch
//   Producer side of the decode stage's 128-bit bundle input. Holds the
//   bundle PC, drives a synchronous-read instruction memory and presents the
//   fetched bundle to decode. Replays the bundle while stalled and emits an
//   all-zero NOP bundle after a taken redirect.
//   Ports:
//     clk            clock
//     rstn           synchronous reset, active-low
//     bus            vliw_fetch_if.master (stall/dec_stall/redirect in,
//                    imem_addr out, imem_data in, inst/inst_pc/inst_valid out)
//   Optional (macro FETCH_PERF_EN):
//     perf_bundles   bundles accepted by decode (inst_valid & ~hold)
//     perf_stall_cyc cycles with hold asserted
// ----------------------------------------------------------------------------
module vliw_fetch #(
    parameter int          PC_W     = 14,
    parameter int          BUNDLE_W = 128,
    parameter int unsigned RESET_PC = 0
) (
    input  logic clk,
    input  logic rstn,
    vliw_fetch_if.master bus
`ifdef FETCH_PERF_EN
    ,
    output logic [31:0] perf_bundles,
    output logic [31:0] perf_stall_cyc
`endif
);

    typedef enum logic [1:0] {
        BUBBLE,
        RUN,
        HOLD
    } state_t;

    state_t              state_q, state_d;
    logic [PC_W-1:0]     addr_q, addr_d;
    logic [PC_W-1:0]     pc_q, pc_d;
    logic [BUNDLE_W-1:0] hold_q, hold_d;
    logic                hold;
    logic                valid;

    assign hold = bus.stall | bus.dec_stall;

    // State register
    always_ff @(posedge clk) begin
        if (!rstn) begin
            state_q <= BUBBLE;
            addr_q  <= PC_W'(RESET_PC);
            pc_q    <= '0;
            hold_q  <= '0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            pc_q    <= pc_d;
            hold_q  <= hold_d;
        end
    end

    // Next state: redirect > hold > advance
    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        pc_d    = pc_q;
        hold_d  = hold_q;
        if (bus.redirect) begin
            addr_d  = bus.redirect_pc;
            state_d = BUBBLE;
            hold_d  = '0;
        end else if (hold) begin
            // The memory output moves on the next edge, so the bundle being
            // shown must be captured now to keep replaying it.
            if (state_q == RUN) begin
                hold_d  = bus.imem_data;
                state_d = HOLD;
            end
        end else begin
            addr_d  = addr_q + PC_W'(1);
            pc_d    = addr_q;
            state_d = RUN;
        end
    end

    // Outputs
    always_comb begin
        bus.inst = '0;
        valid    = 1'b0;
        case (state_q)
            RUN: begin
                bus.inst = bus.imem_data;
                valid    = 1'b1;
            end
            HOLD: begin
                bus.inst = hold_q;
                valid    = 1'b1;
            end
            default: begin
                bus.inst = '0;
                valid    = 1'b0;
            end
        endcase
        bus.inst_valid = valid;
        bus.inst_pc    = pc_q;
        bus.imem_addr  = addr_q;
    end

`ifdef FETCH_PERF_EN
    always_ff @(posedge clk) begin
        if (!rstn) begin
            perf_bundles   <= '0;
            perf_stall_cyc <= '0;
        end else begin
            if (valid && !hold) perf_bundles <= perf_bundles + 32'd1;
            if (hold)           perf_stall_cyc <= perf_stall_cyc + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_vliw_fetch.sv
// ----------------------------------------------------------------------------
// tb_vliw_fetch
//   Directed scenario table followed by randomized stall/redirect/reset
//   traffic, checked against a bundle-stream model of the fetch stage.
// ----------------------------------------------------------------------------
module tb_vliw_fetch;
    localparam int          PC_W     = 14;
    localparam int          BUNDLE_W = 128;
    localparam int unsigned RESET_PC = 0;

    logic clk = 1'b0;
    logic rstn;
    always #5 clk = ~clk;

    vliw_fetch_if #(.PC_W(PC_W), .BUNDLE_W(BUNDLE_W)) bus ();

`ifdef FETCH_PERF_EN
    logic [31:0] perf_bundles;
    logic [31:0] perf_stall_cyc;
`endif

    vliw_fetch #(.PC_W(PC_W), .BUNDLE_W(BUNDLE_W), .RESET_PC(RESET_PC)) dut (
        .clk  (clk),
        .rstn (rstn),
        .bus  (bus)
`ifdef FETCH_PERF_EN
        ,
        .perf_bundles   (perf_bundles),
        .perf_stall_cyc (perf_stall_cyc)
`endif
    );

    // Memory contents: address replicated in every 32-bit slot.
    function automatic logic [BUNDLE_W-1:0] mem_word(input logic [PC_W-1:0] a);
        logic [31:0] w;
        w = {{(32-PC_W){1'b0}}, a};
        return {4{w}};
    endfunction

    // Synchronous-read instruction memory
    always @(posedge clk) bus.imem_data <= mem_word(bus.imem_addr);

    int n_cmp = 0;
    int n_err = 0;

    task automatic chk(input string name, input logic [BUNDLE_W-1:0] act, input logic [BUNDLE_W-1:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Model: the stream of bundles decode sees.
    logic            m_valid = 1'b0;
    logic [PC_W-1:0] m_pc    = '0;
    logic [PC_W-1:0] m_next  = PC_W'(RESET_PC);
    logic [31:0]     m_bund  = '0;
    logic [31:0]     m_stl   = '0;

    task automatic step(input logic r, input logic s, input logic d, input logic rd, input logic [PC_W-1:0] rpc);
        logic h;
        rstn            = r;
        bus.stall       = s;
        bus.dec_stall   = d;
        bus.redirect    = rd;
        bus.redirect_pc = rpc;
        h = s | d;
        if (!r) begin
            m_bund = '0;
            m_stl  = '0;
        end else begin
            if (m_valid && !h) m_bund = m_bund + 32'd1;
            if (h)             m_stl  = m_stl + 32'd1;
        end
        if (!r) begin
            m_valid = 1'b0;
            m_pc    = '0;
            m_next  = PC_W'(RESET_PC);
        end else if (rd) begin
            m_valid = 1'b0;
            m_next  = rpc;
        end else if (!h) begin
            m_valid = 1'b1;
            m_pc    = m_next;
            m_next  = m_next + PC_W'(1);
        end
        @(posedge clk);
        #1;
        chk("model_valid", BUNDLE_W'(bus.inst_valid), BUNDLE_W'(m_valid));
        chk("model_inst", bus.inst, m_valid ? mem_word(m_pc) : '0);
        if (m_valid) chk("model_pc", BUNDLE_W'(bus.inst_pc), BUNDLE_W'(m_pc));
        chk("model_addr", BUNDLE_W'(bus.imem_addr), BUNDLE_W'(m_next));
    endtask

    task automatic perf_chk();
`ifdef FETCH_PERF_EN
        chk("perf_bundles", BUNDLE_W'(perf_bundles), BUNDLE_W'(m_bund));
        chk("perf_stall_cyc", BUNDLE_W'(perf_stall_cyc), BUNDLE_W'(m_stl));
`endif
    endtask

    typedef struct {
        logic            rstn;
        logic            stall;
        logic            dec;
        logic            redir;
        logic [PC_W-1:0] rpc;
        logic            ev;
        logic [PC_W-1:0] epc;
        logic [PC_W-1:0] eaddr;
        logic            chk_pc;
        logic            scn_end;
    } vec_t;

    vec_t tbl[$];

    task automatic add(input int r, input int s, input int d, input int rd, input int rpc,
                       input int ev, input int epc, input int eaddr, input int cp, input int se);
        vec_t v;
        v.rstn = r[0]; v.stall = s[0]; v.dec = d[0]; v.redir = rd[0];
        v.rpc = PC_W'(rpc); v.ev = ev[0]; v.epc = PC_W'(epc); v.eaddr = PC_W'(eaddr);
        v.chk_pc = cp[0]; v.scn_end = se[0];
        tbl.push_back(v);
    endtask

    initial begin
        rstn = 1'b0;
        bus.stall = 1'b0;
        bus.dec_stall = 1'b0;
        bus.redirect = 1'b0;
        bus.redirect_pc = '0;

        // Reset, then stream bundles 0..5
        add(0,0,0,0,0,     0,0,0,       1,0);
        add(0,0,0,0,0,     0,0,0,       1,0);
        for (int i = 0; i < 6; i++) add(1,0,0,0,0, 1,i,i+1, 0, (i == 5) ? 1 : 0);
        // 3-cycle stall on bundle 5
        add(1,1,0,0,0,     1,5,6,       0,0);
        add(1,1,0,0,0,     1,5,6,       0,0);
        add(1,1,0,0,0,     1,5,6,       0,0);
        add(1,0,0,0,0,     1,6,7,       0,0);
        add(1,0,0,0,0,     1,7,8,       0,1);
        // dec_stall for 1 cycle on bundle 9
        add(1,0,0,0,0,     1,8,9,       0,0);
        add(1,0,0,0,0,     1,9,10,      0,0);
        add(1,0,1,0,0,     1,9,10,      0,0);
        add(1,0,0,0,0,     1,10,11,     0,1);
        // Redirect to 0x120 while showing bundle 4
        add(1,0,0,1,4,     0,0,4,       0,0);
        add(1,0,0,0,0,     1,4,5,       0,0);
        add(1,0,0,1,'h120, 0,0,'h120,   0,0);
        add(1,0,0,0,0,     1,'h120,'h121, 0,0);
        add(1,0,0,0,0,     1,'h121,'h122, 0,1);
        // Redirect with simultaneous stall, stall held 2 more cycles
        add(1,1,0,1,'h40,  0,0,'h40,    0,0);
        add(1,1,0,0,0,     0,0,'h40,    0,0);
        add(1,1,0,0,0,     0,0,'h40,    0,0);
        add(1,0,0,0,0,     1,'h40,'h41, 0,1);
        // Wrap, then reset during HOLD
        add(1,0,0,1,'h3FFE, 0,0,'h3FFE,  0,0);
        add(1,0,0,0,0,     1,'h3FFE,'h3FFF, 0,0);
        add(1,0,0,0,0,     1,'h3FFF,0,  0,0);
        add(1,0,0,0,0,     1,0,1,       0,0);
        add(1,1,0,0,0,     1,0,1,       0,0);
        add(0,1,0,0,0,     0,0,0,       1,0);
        add(1,0,0,0,0,     1,0,1,       0,1);

        foreach (tbl[i]) begin
            step(tbl[i].rstn, tbl[i].stall, tbl[i].dec, tbl[i].redir, tbl[i].rpc);
            chk($sformatf("tbl%0d_valid", i), BUNDLE_W'(bus.inst_valid), BUNDLE_W'(tbl[i].ev));
            chk($sformatf("tbl%0d_inst", i), bus.inst, tbl[i].ev ? mem_word(tbl[i].epc) : '0);
            if (tbl[i].ev || tbl[i].chk_pc)
                chk($sformatf("tbl%0d_pc", i), BUNDLE_W'(bus.inst_pc), BUNDLE_W'(tbl[i].epc));
            chk($sformatf("tbl%0d_addr", i), BUNDLE_W'(bus.imem_addr), BUNDLE_W'(tbl[i].eaddr));
            if (tbl[i].scn_end) perf_chk();
        end

        // Randomized traffic
        for (int n = 0; n < 3000; n++) begin
            logic            r, s, d, rd;
            logic [PC_W-1:0] rpc;
            r   = ($urandom_range(0, 99) >= 2);
            s   = ($urandom_range(0, 99) < 20);
            d   = ($urandom_range(0, 99) < 10);
            rd  = ($urandom_range(0, 99) < 8);
            rpc = ($urandom_range(0, 3) == 0) ? PC_W'(14'h3FFC + PC_W'($urandom_range(0, 3)))
                                               : PC_W'($urandom);
            step(r, s, d, rd, rpc);
            if (n % 500 == 499) perf_chk();
        end
        perf_chk();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
